// File: rtl/sf_code_packer.sv
// sf_code_packer: packs MSB-first variable-length codewords into OUT_W words.
// Optional statistics ports are built in when SF_PACKER_STATS_EN is defined.
module sf_code_packer #(
    parameter int OUT_W   = 8,
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               code_valid,
    output logic               code_ready,
    input  logic [MAX_LEN-1:0] codeword,
    input  logic [LEN_W-1:0]   code_len,
    input  logic               flush,
    output logic               word_valid,
    input  logic               word_ready,
    output logic [OUT_W-1:0]   word_data,
    output logic               word_last,
    output logic               flush_done
`ifdef SF_PACKER_STATS_EN
    ,
    output logic [31:0]        bit_count,
    output logic [LEN_W-1:0]   pad_bits
`endif
);

    localparam int BUF_W  = OUT_W + MAX_LEN;
    localparam int FILL_W = $clog2(BUF_W + 1);

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        PAD
    } state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               wv_q, wv_d;
    logic [OUT_W-1:0]   wd_q, wd_d;
    logic               wl_q, wl_d;
    logic               fd_q, fd_d;

    logic [LEN_W-1:0]   len_sat;
    logic [MAX_LEN-1:0] code_just;
    logic [BUF_W-1:0]   code_ext;
    logic               slot_free;
    logic               full;
    logic               accept;
    logic               emit;

`ifdef SF_PACKER_STATS_EN
    logic [31:0]        bc_q, bc_d;
    logic [LEN_W-1:0]   pad_q, pad_d;
`endif

    // Accept is only possible below a full word, so it never collides with emit.
    assign full       = fill_q >= FILL_W'(OUT_W);
    assign slot_free  = !wv_q || word_ready;
    assign code_ready = !rst && (state_q == ACCUM) && !full;
    assign accept     = code_valid && code_ready;
    assign emit       = full && slot_free && (state_q != PAD);

    // Saturate the length and left-justify the code so it lands just below fill.
    always_comb begin
        len_sat   = (code_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : code_len;
        code_just = codeword << (LEN_W'(MAX_LEN) - len_sat);
        code_ext  = {code_just, {OUT_W{1'b0}}};
    end

    // Next-state: buffer, output slot and block-flush sequencing.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        wv_d    = wv_q;
        wd_d    = wd_q;
        wl_d    = wl_q;
        fd_d    = 1'b0;
`ifdef SF_PACKER_STATS_EN
        bc_d    = bc_q;
        pad_d   = pad_q;
`endif

        if (wv_q && word_ready) begin
            wv_d = 1'b0;
            wl_d = 1'b0;
        end

        if (accept) begin
            buf_d  = buf_q | (code_ext >> fill_q);
            fill_d = fill_q + FILL_W'(len_sat);
`ifdef SF_PACKER_STATS_EN
            bc_d   = bc_q + 32'(len_sat);
`endif
        end

        if (emit) begin
            wd_d   = buf_q[BUF_W-1 -: OUT_W];
            wv_d   = 1'b1;
            wl_d   = (state_q == DRAIN) && (fill_q == FILL_W'(OUT_W));
            buf_d  = buf_q << OUT_W;
            fill_d = fill_q - FILL_W'(OUT_W);
        end

        unique case (state_q)
            ACCUM: begin
                if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (!full && slot_free) begin
                    if (fill_q != '0) begin
                        state_d = PAD;
                    end else begin
                        fd_d    = 1'b1;
                        state_d = ACCUM;
                    end
                end
            end
            PAD: begin
                if (slot_free) begin
                    wd_d    = buf_q[BUF_W-1 -: OUT_W];
                    wv_d    = 1'b1;
                    wl_d    = 1'b1;
                    buf_d   = '0;
                    fill_d  = '0;
                    fd_d    = 1'b1;
                    state_d = ACCUM;
`ifdef SF_PACKER_STATS_EN
                    pad_d   = LEN_W'(FILL_W'(OUT_W) - fill_q);
`endif
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State registers; reset discards buffered bits and any pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            buf_q   <= '0;
            fill_q  <= '0;
            wv_q    <= 1'b0;
            wd_q    <= '0;
            wl_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            wv_q    <= wv_d;
            wd_q    <= wd_d;
            wl_q    <= wl_d;
            fd_q    <= fd_d;
        end
    end

`ifdef SF_PACKER_STATS_EN
    // Statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bc_q  <= '0;
            pad_q <= '0;
        end else begin
            bc_q  <= bc_d;
            pad_q <= pad_d;
        end
    end

    assign bit_count = bc_q;
    assign pad_bits  = pad_q;
`endif

    assign word_valid = wv_q;
    assign word_data  = wd_q;
    assign word_last  = wl_q;
    assign flush_done = fd_q;

endmodule

// File: tb/tb_sf_code_packer.sv
// tb_sf_code_packer: table-driven cycle vectors plus a mid-operation reset test.
// Inputs change at negedge; outputs are sampled 1 ns later.
module tb_sf_code_packer;

    logic       clk;
    logic       rst;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] codeword;
    logic [3:0] code_len;
    logic       flush;
    logic       word_valid;
    logic       word_ready;
    logic [7:0] word_data;
    logic       word_last;
    logic       flush_done;
`ifdef SF_PACKER_STATS_EN
    logic [31:0] bit_count;
    logic [3:0]  pad_bits;
`endif

    int checks   = 0;
    int failures = 0;

    sf_code_packer #(.OUT_W(8), .MAX_LEN(8), .LEN_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .codeword   (codeword),
        .code_len   (code_len),
        .flush      (flush),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_last  (word_last),
        .flush_done (flush_done)
`ifdef SF_PACKER_STATS_EN
        ,
        .bit_count  (bit_count),
        .pad_bits   (pad_bits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] cw;
        logic [3:0] len;
        logic       fl;
        logic       wr;
        logic       cr;
        logic       wv;
        logic [7:0] wd;
        logic       wl;
        logic       fd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] cw,
                       input logic [3:0] len, input logic fl,
                       input logic wr, input logic cr, input logic wv,
                       input logic [7:0] wd, input logic wl,
                       input logic fd);
        vec_t r;
        r.v = v; r.cw = cw; r.len = len; r.fl = fl; r.wr = wr;
        r.cr = cr; r.wv = wv; r.wd = wd; r.wl = wl; r.fd = fd;
        vecs.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        code_valid = 1'b0;
        codeword   = 8'h00;
        code_len   = 4'd0;
        flush      = 1'b0;
    endtask

    initial begin
        bit got;
        rst        = 1'b1;
        word_ready = 1'b1;
        idle_inputs();

        // v cw len fl wr | cr wv wd wl fd
        // basic packing
        add(1, 8'b101,      3, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 8'b11001,    5, 0, 1, 1, 0, 8'h00, 0, 0);
        add(0, 8'h00,       0, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00,       0, 0, 1, 1, 1, 8'hB9, 0, 0);
        add(0, 8'h00,       0, 0, 1, 1, 0, 8'hB9, 0, 0);
        // straddle, then flush through PAD
        add(1, 8'b101010,   6, 0, 1, 1, 0, 8'hB9, 0, 0);
        add(1, 8'b111111,   6, 0, 1, 1, 0, 8'hB9, 0, 0);
        add(0, 8'h00,       0, 0, 1, 0, 0, 8'hB9, 0, 0);
        add(0, 8'h00,       0, 1, 1, 1, 1, 8'hAB, 0, 0);
        add(0, 8'h00,       0, 0, 1, 0, 0, 8'hAB, 0, 0);
        add(0, 8'h00,       0, 0, 1, 0, 0, 8'hAB, 0, 0);
        add(0, 8'h00,       0, 0, 1, 1, 1, 8'hF0, 1, 1);
        add(0, 8'h00,       0, 0, 1, 1, 0, 8'hF0, 0, 0);
        // empty flush
        add(0, 8'h00,       0, 1, 1, 1, 0, 8'hF0, 0, 0);
        add(0, 8'h00,       0, 0, 1, 0, 0, 8'hF0, 0, 0);
        add(0, 8'h00,       0, 0, 1, 1, 0, 8'hF0, 0, 1);
        add(0, 8'h00,       0, 0, 1, 1, 0, 8'hF0, 0, 0);
        // len 0 no-op, len 12 saturates to 8
        add(1, 8'hFF,       0, 0, 1, 1, 0, 8'hF0, 0, 0);
        add(1, 8'hA5,      12, 0, 1, 1, 0, 8'hF0, 0, 0);
        add(0, 8'h00,       0, 0, 1, 0, 0, 8'hF0, 0, 0);
        add(0, 8'h00,       0, 0, 1, 1, 1, 8'hA5, 0, 0);
        // eight 1-bit codes
        add(1, 8'h01,       1, 0, 1, 1, 0, 8'hA5, 0, 0);
        add(1, 8'h00,       1, 0, 1, 1, 0, 8'hA5, 0, 0);
        add(1, 8'h01,       1, 0, 1, 1, 0, 8'hA5, 0, 0);
        add(1, 8'h01,       1, 0, 1, 1, 0, 8'hA5, 0, 0);
        add(1, 8'h00,       1, 0, 1, 1, 0, 8'hA5, 0, 0);
        add(1, 8'h00,       1, 0, 1, 1, 0, 8'hA5, 0, 0);
        add(1, 8'h01,       1, 0, 1, 1, 0, 8'hA5, 0, 0);
        add(1, 8'h00,       1, 0, 1, 1, 0, 8'hA5, 0, 0);
        add(0, 8'h00,       0, 0, 1, 0, 0, 8'hA5, 0, 0);
        add(0, 8'h00,       0, 0, 1, 1, 1, 8'hB2, 0, 0);
        add(0, 8'h00,       0, 0, 1, 1, 0, 8'hB2, 0, 0);
        // backpressure
        add(1, 8'hFF,       8, 0, 0, 1, 0, 8'hB2, 0, 0);
        add(1, 8'b1111,     4, 0, 0, 0, 0, 8'hB2, 0, 0);
        add(1, 8'h3C,       8, 0, 0, 1, 1, 8'hFF, 0, 0);
        add(1, 8'b1111,     4, 0, 0, 0, 1, 8'hFF, 0, 0);
        add(1, 8'b1111,     4, 0, 0, 0, 1, 8'hFF, 0, 0);
        add(1, 8'b1111,     4, 0, 1, 0, 1, 8'hFF, 0, 0);
        add(1, 8'b1111,     4, 0, 0, 1, 1, 8'h3C, 0, 0);
        add(1, 8'b0000,     4, 0, 1, 1, 1, 8'h3C, 0, 0);
        add(0, 8'h00,       0, 0, 1, 0, 0, 8'h3C, 0, 0);
        add(0, 8'h00,       0, 0, 1, 1, 1, 8'hF0, 0, 0);
        add(0, 8'h00,       0, 0, 1, 1, 0, 8'hF0, 0, 0);
        // coincident accept + flush, full word drained with word_last
        add(1, 8'h81,       8, 1, 1, 1, 0, 8'hF0, 0, 0);
        add(0, 8'h00,       0, 0, 1, 0, 0, 8'hF0, 0, 0);
        add(0, 8'h00,       0, 0, 1, 0, 1, 8'h81, 1, 0);
        add(0, 8'h00,       0, 0, 1, 1, 0, 8'h81, 0, 1);
        add(0, 8'h00,       0, 0, 1, 1, 0, 8'h81, 0, 0);

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_code_ready", 32'(code_ready), 32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_word_data",  32'(word_data),  32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            code_valid = vecs[i].v;
            codeword   = vecs[i].cw;
            code_len   = vecs[i].len;
            flush      = vecs[i].fl;
            word_ready = vecs[i].wr;
            #1;
            chk($sformatf("v%0d_code_ready", i), 32'(code_ready), 32'(vecs[i].cr));
            chk($sformatf("v%0d_word_valid", i), 32'(word_valid), 32'(vecs[i].wv));
            chk($sformatf("v%0d_word_data", i),  32'(word_data),  32'(vecs[i].wd));
            chk($sformatf("v%0d_word_last", i),  32'(word_last),  32'(vecs[i].wl));
            chk($sformatf("v%0d_flush_done", i), 32'(flush_done), 32'(vecs[i].fd));
        end

        // reset mid-operation: word pending and 5 bits buffered
        @(negedge clk);
        idle_inputs();
        word_ready = 1'b0;
        code_valid = 1'b1;
        codeword   = 8'hFF;
        code_len   = 4'd8;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        code_valid = 1'b1;
        codeword   = 8'b10110;
        code_len   = 4'd5;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("pre_rst_word_valid", 32'(word_valid), 32'd1);
        chk("pre_rst_word_data",  32'(word_data),  32'hFF);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_word_valid", 32'(word_valid), 32'd0);
        chk("async_rst_word_last",  32'(word_last),  32'd0);
        chk("async_rst_flush_done", 32'(flush_done), 32'd0);
        chk("async_rst_code_ready", 32'(code_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        word_ready = 1'b1;
        #1;
        chk("post_rst_code_ready", 32'(code_ready), 32'd1);
        chk("post_rst_word_valid", 32'(word_valid), 32'd0);
        @(negedge clk);
        code_valid = 1'b1;
        codeword   = 8'b101;
        code_len   = 4'd3;
        @(negedge clk);
        codeword   = 8'b11001;
        code_len   = 4'd5;
        @(negedge clk);
        idle_inputs();
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            #1;
            if (word_valid) got = 1'b1;
            else @(negedge clk);
        end
        chk("post_rst_word_seen", 32'(got), 32'd1);
        chk("post_rst_word_data", 32'(word_data), 32'hB9);
        chk("post_rst_word_last", 32'(word_last), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
